// File: rtl/ale_pkg.sv
// Shared types and helpers for the atmospheric light estimator.
//   ale_state_e  : controller states
//   ale_clog2    : ceiling log2 for parameter arithmetic
//   ale_entry_w  : width of one packed top-k entry {dark, chan_min[0..NUM_CH-1]}
//   ale_recip    : saturating Q0.inv_w reciprocal
package ale_pkg;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_AVG,
    ST_RECIP,
    ST_DONE
  } ale_state_e;

  function automatic int unsigned ale_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ale_entry_w(input int unsigned data_w, input int unsigned num_ch);
    return data_w * (num_ch + 1);
  endfunction

  localparam int unsigned ALE_DEF_DATA_W  = 8;
  localparam int unsigned ALE_DEF_NUM_CH  = 3;
  localparam int unsigned ALE_DEF_ENTRY_W = ale_entry_w(ALE_DEF_DATA_W, ALE_DEF_NUM_CH);

  // A of 0 or 1 saturates to all-ones; otherwise floor(2^inv_w / A).
  function automatic logic [31:0] ale_recip(input logic [31:0] a, input int unsigned inv_w);
    logic [63:0] one;
    one = 64'd1 << inv_w;
    if (a <= 32'd1) return 32'(one - 64'd1);
    return 32'(one / {32'd0, a});
  endfunction

endpackage

// File: rtl/ale_topk_table.sv
// Sorted top-k candidate table (descending dark value).
//   clk, rst_n  : clock, async active-low reset
//   i_clr       : empty the table (priority over i_upd)
//   i_upd       : offer i_cand for insertion
//   i_cand      : {dark, chan_min[0], ..., chan_min[NUM_CH-1]}, dark in MSBs
//   o_entries   : entry k at [k*ENTRY_W +: ENTRY_W], entry 0 brightest; invalid entries read 0
module ale_topk_table
  import ale_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned NUM_CH  = 3,
  parameter  int unsigned TOPK    = 4,
  localparam int unsigned ENTRY_W = ale_entry_w(DATA_W, NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_upd,
  input  logic [ENTRY_W-1:0]      i_cand,
  output logic [TOPK*ENTRY_W-1:0] o_entries
);

  logic [TOPK-1:0]    r_valid;
  logic [ENTRY_W-1:0] r_ent     [TOPK];
  logic [TOPK-1:0]    w_take;
  logic [TOPK-1:0]    w_nxt_v;
  logic [ENTRY_W-1:0] w_nxt_ent [TOPK];
  logic [DATA_W-1:0]  w_cand_dark;

  assign w_cand_dark = i_cand[ENTRY_W-1 -: DATA_W];

  // Strict compare keeps earlier equal entries above later ones. Valid entries
  // are contiguous from slot 0, so w_take is monotonic: the first set bit is
  // the insertion slot and every slot below it takes its upper neighbour.
  always_comb begin
    for (int unsigned i = 0; i < TOPK; i++) begin
      w_take[i]    = ~r_valid[i] | (w_cand_dark > r_ent[i][ENTRY_W-1 -: DATA_W]);
      w_nxt_v[i]   = r_valid[i];
      w_nxt_ent[i] = r_ent[i];
      if (w_take[i]) begin
        w_nxt_v[i]   = 1'b1;
        w_nxt_ent[i] = i_cand;
      end
    end
    for (int unsigned i = 1; i < TOPK; i++) begin
      if (w_take[i-1]) begin
        w_nxt_v[i]   = r_valid[i-1];
        w_nxt_ent[i] = r_ent[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < TOPK; i++) r_ent[i] <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < TOPK; i++) r_ent[i] <= '0;
    end else if (i_upd) begin
      r_valid <= w_nxt_v;
      r_ent   <= w_nxt_ent;
    end
  end

  always_comb begin
    o_entries = '0;
    for (int unsigned i = 0; i < TOPK; i++) o_entries[i*ENTRY_W +: ENTRY_W] = r_ent[i];
  end

endmodule

// File: rtl/ale_topk_estimator.sv
// Atmospheric light estimator: per frame, keeps the TOPK windows with the
// brightest dark channel and averages their channel minima into A and 1/A.
//   clk, rst_n     : clock, async active-low reset
//   in_valid/ready : window beat handshake (ready only while accumulating)
//   in_sof         : first-of-frame marker; mid-frame it restarts the frame
//   in_window      : WIN*WIN pixels, pixel 0 and channel 0 in MSBs
//   atm_light      : A per channel (channel 0 in MSBs), held
//   inv_atm_light  : saturated Q0.INV_W reciprocal of A per channel, held
//   atm_valid      : sticky, set by the first completed frame
//   frame_done     : one-cycle pulse when held outputs update
//   err_sof        : one-cycle pulse for in_sof arriving mid-frame
module ale_topk_estimator
  import ale_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned WIN    = 3,
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned TOPK   = 4,
  parameter int unsigned INV_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sof,
  input  logic [WIN*WIN*NUM_CH*DATA_W-1:0]  in_window,
  output logic [NUM_CH*DATA_W-1:0]          atm_light,
  output logic [NUM_CH*INV_W-1:0]           inv_atm_light,
  output logic                              atm_valid,
  output logic                              frame_done,
  output logic                              err_sof
);

  localparam int unsigned PIX_W   = NUM_CH * DATA_W;
  localparam int unsigned NPIX    = WIN * WIN;
  localparam int unsigned LOGK    = ale_clog2(TOPK);
  localparam int unsigned ENTRY_W = ale_entry_w(DATA_W, NUM_CH);
  localparam int unsigned NBEAT   = IMG_W * IMG_H;
  localparam int unsigned CNT_W   = ale_clog2(NBEAT + 1);
  localparam int unsigned SUM_W   = DATA_W + LOGK;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEAT - 1);

  ale_state_e r_state, w_state_nxt;
  logic       r_drain_last;
  logic       w_drain, w_avg_en, w_recip_en, w_done;
  logic       w_accept, w_err, w_adv, w_tbl_upd, w_tbl_clr;
  logic [CNT_W-1:0] r_cnt, w_beat_idx;

  logic [DATA_W-1:0] w_s1_min [NUM_CH];
  logic [DATA_W-1:0] r_s1_min [NUM_CH];
  logic              r_s1_v;
  logic [DATA_W-1:0] w_s2_dark, r_s2_dark;
  logic [DATA_W-1:0] r_s2_min [NUM_CH];
  logic              r_s2_v;

  logic [ENTRY_W-1:0]      w_cand;
  logic [TOPK*ENTRY_W-1:0] w_entries;
  logic [SUM_W-1:0]        w_sum [NUM_CH];
  logic [DATA_W-1:0]       w_avg [NUM_CH];
  logic [DATA_W-1:0]       r_avg [NUM_CH];
  logic [INV_W-1:0]        r_inv [NUM_CH];

  logic [NUM_CH*DATA_W-1:0] r_atm_light;
  logic [NUM_CH*INV_W-1:0]  r_inv_atm;
  logic                     r_atm_valid, r_frame_done, r_err_sof;

  assign in_ready   = (r_state == ST_ACCUM);
  assign w_accept   = in_valid & in_ready;
  assign w_err      = w_accept & in_sof & (r_cnt != '0);
  assign w_beat_idx = w_err ? '0 : r_cnt;
  assign w_adv      = w_accept | w_drain;
  assign w_tbl_upd  = w_adv & r_s2_v & ~w_err;
  assign w_tbl_clr  = w_done | w_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACCUM;
      r_drain_last <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_last <= (r_state == ST_DRAIN) & ~r_drain_last;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain     = 1'b0;
    w_avg_en    = 1'b0;
    w_recip_en  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_ACCUM: if (w_accept && (w_beat_idx == LAST_IDX)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        w_drain = 1'b1;
        if (r_drain_last) w_state_nxt = ST_AVG;
      end
      ST_AVG: begin
        w_avg_en    = 1'b1;
        w_state_nxt = ST_RECIP;
      end
      ST_RECIP: begin
        w_recip_en  = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (w_accept) r_cnt <= (w_beat_idx == LAST_IDX) ? '0 : w_beat_idx + CNT_W'(1);
    else if (w_done)   r_cnt <= '0;
  end

  // Stage 1: per-channel minimum across all pixels of the window.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) w_s1_min[c] = '1;
    for (int unsigned p = 0; p < NPIX; p++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (in_window[(NPIX-1-p)*PIX_W + (NUM_CH-1-c)*DATA_W +: DATA_W] < w_s1_min[c])
          w_s1_min[c] = in_window[(NPIX-1-p)*PIX_W + (NUM_CH-1-c)*DATA_W +: DATA_W];
      end
    end
  end

  // Stage 2: dark channel = minimum over the channel minima.
  always_comb begin
    w_s2_dark = r_s1_min[0];
    for (int unsigned c = 1; c < NUM_CH; c++) begin
      if (r_s1_min[c] < w_s2_dark) w_s2_dark = r_s1_min[c];
    end
  end

  // A restarting beat enters S1 as beat 0 while the stale S2 content is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s2_dark <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_s1_min[c] <= '0;
        r_s2_min[c] <= '0;
      end
    end else if (w_adv) begin
      r_s1_min  <= w_s1_min;
      r_s1_v    <= w_accept;
      r_s2_min  <= r_s1_min;
      r_s2_dark <= w_s2_dark;
      r_s2_v    <= r_s1_v & ~w_err;
    end
  end

  always_comb begin
    w_cand = '0;
    w_cand[ENTRY_W-1 -: DATA_W] = r_s2_dark;
    for (int unsigned c = 0; c < NUM_CH; c++) w_cand[(NUM_CH-1-c)*DATA_W +: DATA_W] = r_s2_min[c];
  end

  ale_topk_table #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .TOPK   (TOPK)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_tbl_clr),
    .i_upd     (w_tbl_upd),
    .i_cand    (w_cand),
    .o_entries (w_entries)
  );

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_sum[c] = '0;
      for (int unsigned k = 0; k < TOPK; k++)
        w_sum[c] = w_sum[c] + SUM_W'(w_entries[k*ENTRY_W + (NUM_CH-1-c)*DATA_W +: DATA_W]);
      w_avg[c] = DATA_W'(w_sum[c] >> LOGK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_atm_light  <= '0;
      r_inv_atm    <= '0;
      r_atm_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_sof    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_avg[c] <= '0;
        r_inv[c] <= '0;
      end
    end else begin
      r_frame_done <= w_done;
      r_err_sof    <= w_err;
      if (w_avg_en) r_avg <= w_avg;
      if (w_recip_en) begin
        for (int unsigned c = 0; c < NUM_CH; c++) r_inv[c] <= INV_W'(ale_recip(32'(r_avg[c]), INV_W));
      end
      if (w_done) begin
        r_atm_valid <= 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          r_atm_light[(NUM_CH-1-c)*DATA_W +: DATA_W] <= r_avg[c];
          r_inv_atm[(NUM_CH-1-c)*INV_W +: INV_W]     <= r_inv[c];
        end
      end
    end
  end

  assign atm_light     = r_atm_light;
  assign inv_atm_light = r_inv_atm;
  assign atm_valid     = r_atm_valid;
  assign frame_done    = r_frame_done;
  assign err_sof       = r_err_sof;

endmodule

// File: tb/tb_ale_topk_estimator.sv
module tb_ale_topk_estimator;

  localparam int DW = 8, NC = 3, WN = 3, IW = 4, IH = 4, K = 4, INVW = 16;
  localparam int NB = IW * IH;
  localparam int NP = WN * WN;
  localparam int WIN_BITS = NP * NC * DW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_sof = 1'b0;
  logic [WIN_BITS-1:0]   in_window = '0;
  logic                  in_ready;
  logic [NC*DW-1:0]      atm_light;
  logic [NC*INVW-1:0]    inv_atm_light;
  logic                  atm_valid, frame_done, err_sof;

  ale_topk_estimator #(
    .DATA_W (DW), .NUM_CH (NC), .WIN (WN), .IMG_W (IW), .IMG_H (IH), .TOPK (K), .INV_W (INVW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sof        (in_sof),
    .in_window     (in_window),
    .atm_light     (atm_light),
    .inv_atm_light (inv_atm_light),
    .atm_valid     (atm_valid),
    .frame_done    (frame_done),
    .err_sof       (err_sof)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc = 0, n_done = 0, n_err = 0, n_frames = 0, last_acc = 0;
  int unsigned mdl   [NB][NC];
  int unsigned exp_a [NC];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_done) n_done <= n_done + 1;
    if (err_sof)    n_err  <= n_err + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned recip_m(input int unsigned a);
    return (a <= 1) ? 65535 : 65536 / a;
  endfunction

  // Window whose per-channel minimum is mdl[b]; other pixels random at or above it.
  function automatic logic [WIN_BITS-1:0] mk_win(input int b, input bit exact);
    logic [WIN_BITS-1:0] w;
    int unsigned v;
    int p;
    w = '0;
    for (int pp = 0; pp < NP; pp++) begin
      for (int c = 0; c < NC; c++) begin
        v = exact ? mdl[b][c] : mdl[b][c] + $urandom_range(0, 255 - mdl[b][c]);
        w[(NP-1-pp)*NC*DW + (NC-1-c)*DW +: DW] = DW'(v);
      end
    end
    for (int c = 0; c < NC; c++) begin
      p = int'($urandom_range(0, NP - 1));
      w[(NP-1-p)*NC*DW + (NC-1-c)*DW +: DW] = DW'(mdl[b][c]);
    end
    return w;
  endfunction

  // Reference: stable ranking by dark value (earliest wins ties), keep K, average.
  task automatic model_frame();
    bit          used [NB];
    int unsigned sum  [NC];
    int          best;
    int unsigned bd, d;
    for (int b = 0; b < NB; b++) used[b] = 1'b0;
    for (int c = 0; c < NC; c++) sum[c] = 0;
    for (int k = 0; k < K; k++) begin
      best = -1;
      bd = 0;
      for (int b = 0; b < NB; b++) begin
        if (!used[b]) begin
          d = mdl[b][0];
          for (int c = 1; c < NC; c++) if (mdl[b][c] < d) d = mdl[b][c];
          if (best < 0 || d > bd) begin
            best = b;
            bd = d;
          end
        end
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        for (int c = 0; c < NC; c++) sum[c] += mdl[best][c];
      end
    end
    for (int c = 0; c < NC; c++) exp_a[c] = sum[c] / K;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [WIN_BITS-1:0] w, input logic sof);
    int unsigned g;
    g = 0;
    in_valid  = 1'b1;
    in_window = w;
    in_sof    = sof;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("ready_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic expect_done(input bit hold);
    int unsigned g;
    g = 0;
    model_frame();
    if (hold) chk("ready_low_while_busy", in_ready, 0);
    while (frame_done !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("done_seen", frame_done, 1);
    // frame_done is registered on the sixth edge counting the accepting edge
    chk("done_latency", cyc - last_acc, 5);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("atm_light[%0d]", c), atm_light[(NC-1-c)*DW +: DW], exp_a[c]);
      chk($sformatf("inv_atm[%0d]", c), inv_atm_light[(NC-1-c)*INVW +: INVW], recip_m(exp_a[c]));
    end
    chk("atm_valid", atm_valid, 1);
    n_frames++;
    @(negedge clk);
    chk("done_pulse_width", frame_done, 0);
  endtask

  task automatic run_frame(input bit exact, input bit hold);
    for (int b = 0; b < NB; b++) send_beat(mk_win(b, exact), b == 0);
    if (hold) begin
      in_valid  = 1'b1;
      in_sof    = 1'b1;
      in_window = '1;
    end else begin
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
    expect_done(hold);
  endtask

  task automatic set_all(input int unsigned m0, input int unsigned m1, input int unsigned m2);
    for (int b = 0; b < NB; b++) begin
      mdl[b][0] = m0;
      mdl[b][1] = m1;
      mdl[b][2] = m2;
    end
  endtask

  task automatic set_beat(input int b, input int unsigned m0, input int unsigned m1, input int unsigned m2);
    mdl[b][0] = m0;
    mdl[b][1] = m1;
    mdl[b][2] = m2;
  endtask

  initial begin
    int unsigned d0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_atm_light", atm_light, 0);
    chk("rst_inv", inv_atm_light, 0);
    chk("rst_atm_valid", atm_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_sof", err_sof, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // uniform frame
    set_all(100, 150, 200);
    run_frame(1'b1, 1'b0);
    chk("uniform_inv_ch0", inv_atm_light[2*INVW +: INVW], 655);

    // four bright candidates among dim background
    set_all(10, 10, 10);
    set_beat(3, 250, 255, 251);
    set_beat(7, 240, 241, 245);
    set_beat(9, 235, 230, 239);
    set_beat(12, 220, 222, 221);
    run_frame(1'b0, 1'b0);

    // ties: a later equal dark value must not displace earlier entries
    set_all(5, 5, 5);
    set_beat(1, 200, 210, 220);
    set_beat(2, 220, 200, 210);
    set_beat(3, 205, 200, 230);
    set_beat(4, 200, 240, 201);
    set_beat(8, 255, 200, 255);
    run_frame(1'b0, 1'b0);

    // reciprocal saturation and 255 boundary
    set_all(0, 1, 255);
    run_frame(1'b0, 1'b0);

    // random frames; first one holds in_valid high while the DUT is busy
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < NB; b++)
        set_beat(b, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      run_frame(1'b0, f == 0);
    end
    chk("no_err_so_far", n_err, 0);

    // mid-frame in_sof restarts; bright pre-restart beats must be discarded
    for (int b = 0; b < 6; b++) begin
      set_beat(0, $urandom_range(210, 255), $urandom_range(210, 255), $urandom_range(210, 255));
      send_beat(mk_win(0, 1'b0), b == 0);
    end
    chk("no_err_before_restart", err_sof, 0);
    for (int b = 0; b < NB; b++)
      set_beat(b, $urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 200));
    send_beat(mk_win(0, 1'b0), 1'b1);
    chk("err_sof_pulse", err_sof, 1);
    chk("held_a_ch0", atm_light[2*DW +: DW], exp_a[0]);
    for (int b = 1; b < NB; b++) begin
      send_beat(mk_win(b, 1'b0), 1'b0);
      if (b == 1) chk("err_sof_one_cycle", err_sof, 0);
    end
    in_valid = 1'b0;
    expect_done(1'b0);

    // async reset mid-frame
    for (int b = 0; b < NB; b++)
      set_beat(b, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    for (int b = 0; b < 5; b++) send_beat(mk_win(b, 1'b0), b == 0);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_atm_light", atm_light, 0);
    chk("midrst_inv", inv_atm_light, 0);
    chk("midrst_atm_valid", atm_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", n_done, d0);
    run_frame(1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("done_count", n_done, n_frames);
    chk("err_count", n_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
